// File: rtl/pipe_reg_bank.sv
// Multi-stage valid/ready pipeline register bank with bubble collapse,
// flush and synchronous load/redirect of the final stage.
module pipe_reg_bank #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush,
  input  logic                       load,
  input  logic [WIDTH-1:0]           load_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_next;
  logic [DEPTH-1:0] up_valid;
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] data_reg  [DEPTH];
  logic [WIDTH-1:0] data_next [DEPTH];
  logic [WIDTH-1:0] up_data   [DEPTH];
  logic [OCC_W-1:0] occ_reg;
  logic [OCC_W-1:0] occ_next;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign up_valid[gi] = in_valid;
        assign up_data[gi]  = in_data;
      end else begin : g_body
        assign up_valid[gi] = valid_reg[gi-1];
        assign up_data[gi]  = data_reg[gi-1];
      end

      // A stage can take a new token unless it and every stage after it is
      // full while the consumer stalls; written flat to avoid a chained loop.
      assign rdy[gi] = out_ready || !(&valid_reg[DEPTH-1:gi]);

      if (gi == DEPTH-1) begin : g_tail
        assign data_next[gi] = flush                       ? data_reg[gi] :
                               load                        ? load_data    :
                               (rdy[gi] && up_valid[gi])   ? up_data[gi]  :
                                                             data_reg[gi];
      end else begin : g_inner
        assign data_next[gi] = (flush || load)             ? data_reg[gi] :
                               (rdy[gi] && up_valid[gi])   ? up_data[gi]  :
                                                             data_reg[gi];
      end
    end
  endgenerate

  always_comb begin
    valid_next = valid_reg;
    if (flush) begin
      valid_next = '0;
    end else if (load) begin
      valid_next            = '0;
      valid_next[DEPTH-1]   = 1'b1;
    end else begin
      valid_next = (rdy & up_valid) | (~rdy & valid_reg);
    end
  end

  // Occupancy is registered from the next-state valid vector so it matches
  // the stage contents after every edge.
  always_comb begin
    occ_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_next = occ_next + OCC_W'(valid_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      valid_reg <= '0;
      occ_reg   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_reg[i] <= RESET_VAL;
      end
    end else begin
      valid_reg <= valid_next;
      occ_reg   <= occ_next;
      data_reg  <= data_next;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = valid_reg[DEPTH-1];
  assign out_data  = data_reg[DEPTH-1];
  assign occupancy = occ_reg;

endmodule
